present_enc_ctrl: RTL and testbench

- Iterative PRESENT block-cipher encryption engine.
- Sequences one round per clock through the round datapath: add round key, 16x S-box layer, bit permutation (present_pbox), key-schedule update.
- Sits between a valid/ready plaintext source and a valid/ready ciphertext sink.
- Processes one 64-bit block at a time.

---
 rtl/present_pkg.sv | 48 ++++
 rtl/present_pbox.sv | 12 +
 rtl/present_sbox_layer.sv | 13 +
 rtl/present_enc_ctrl.sv | 112 +++++++++++
 tb/tb_present_enc_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/present_pkg.sv
// Shared PRESENT constants, FSM state type and the combinational helper
// functions used by the round datapath and the key schedule.
package present_pkg;

  localparam int NUM_ROUNDS_DEF = 31;

  // Nibble i of this table is S(i): C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2
  localparam logic [63:0] SBOX_TBL = 64'h2174_8FE3_DA09_B65C;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_e;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] sbox_layer64(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      y[4*i +: 4] = sbox4(x[4*i +: 4]);
    end
    return y;
  endfunction

  function automatic logic [79:0] key_update_80(input logic [79:0] k,
                                                input logic [4:0]  rnd);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox4(r[79:76]);
    r[19:15]   = r[19:15] ^ rnd;
    return r;
  endfunction

  function automatic logic [127:0] key_update_128(input logic [127:0] k,
                                                  input logic [4:0]   rnd);
    logic [127:0] r;
    r          = {k[66:0], k[127:67]};
    r[127:124] = sbox4(r[127:124]);
    r[123:120] = sbox4(r[123:120]);
    r[66:62]   = r[66:62] ^ rnd;
    return r;
  endfunction

endpackage

// File: rtl/present_pbox.sv
// PRESENT bit permutation: input bit i moves to 16*i mod 63, bit 63 stays.
module present_pbox (
  input  logic [63:0] din,
  output logic [63:0] dout
);

  for (genvar i = 0; i < 64; i++) begin : g_p
    localparam int P = (i == 63) ? 63 : (16 * i) % 63;
    assign dout[P] = din[i];
  end

endmodule

// File: rtl/present_sbox_layer.sv
// Sixteen parallel 4-bit PRESENT S-boxes over a 64-bit state word.
module present_sbox_layer
  import present_pkg::*;
(
  input  logic [63:0] din,
  output logic [63:0] dout
);

  for (genvar i = 0; i < 16; i++) begin : g_sb
    assign dout[4*i +: 4] = sbox4(din[4*i +: 4]);
  end

endmodule

// File: rtl/present_enc_ctrl.sv
// Iterative PRESENT encryption engine: one round per clock between a
// valid/ready plaintext source and a valid/ready ciphertext sink.
module present_enc_ctrl
  import present_pkg::*;
#(
  parameter int KEY_LEN    = 80,
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [63:0]        in_pt,
  input  logic [KEY_LEN-1:0] in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        out_ct,
  output logic               busy
);

  fsm_e               st_q, st_d;
  logic [63:0]        state_q;
  logic [63:0]        out_ct_q;
  logic [KEY_LEN-1:0] key_q;
  logic [KEY_LEN-1:0] key_upd;
  logic [4:0]         rnd_q;
  logic [63:0]        rk;
  logic [63:0]        sb_out;
  logic [63:0]        p_out;
  logic               load;
  logic               last;

  if (KEY_LEN == 80) begin : g_k80
    assign key_upd = key_update_80(key_q, rnd_q);
  end else if (KEY_LEN == 128) begin : g_k128
    assign key_upd = key_update_128(key_q, rnd_q);
  end else begin : g_bad_key_len
    $error("present_enc_ctrl: KEY_LEN must be 80 or 128");
  end

  // Round datapath: add round key, S-box layer, bit permutation
  assign rk = key_q[KEY_LEN-1 -: 64];

  present_sbox_layer u_sbox (
    .din  (state_q ^ rk),
    .dout (sb_out)
  );

  present_pbox u_pbox (
    .din  (sb_out),
    .dout (p_out)
  );

  always_comb begin
    st_d = st_q;
    load = 1'b0;
    last = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (in_valid) begin
          load = 1'b1;
          st_d = RUN;
        end
      end
      RUN: begin
        if (rnd_q == 5'(NUM_ROUNDS)) begin
          last = 1'b1;
          st_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // Round/key registers; the final whitening key comes straight from key_upd
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= '0;
      key_q    <= '0;
      rnd_q    <= '0;
      out_ct_q <= '0;
    end else begin
      if (load) begin
        state_q <= in_pt;
        key_q   <= in_key;
        rnd_q   <= 5'd1;
      end else if (st_q == RUN) begin
        state_q <= p_out;
        key_q   <= key_upd;
        rnd_q   <= last ? rnd_q : rnd_q + 5'd1;
      end
      if (last) out_ct_q <= p_out ^ key_upd[KEY_LEN-1 -: 64];
    end
  end

  assign in_ready  = (st_q == IDLE);
  assign out_valid = (st_q == DONE);
  assign busy      = (st_q != IDLE);
  assign out_ct    = out_ct_q;

endmodule

// File: tb/tb_present_enc_ctrl.sv
// Scoreboard bench for present_enc_ctrl: 80-bit directed vectors and
// 128-bit random blocks checked against an independent reference model.
module tb_present_enc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         iv80, ir80, ov80, or80, busy80;
  logic [63:0]  pt80, ct80;
  logic [79:0]  key80;
  logic         iv128, ir128, ov128, or128, busy128;
  logic [63:0]  pt128, ct128;
  logic [127:0] key128;

  present_enc_ctrl #(.KEY_LEN(80)) dut80 (
    .clk(clk), .rst(rst), .in_valid(iv80), .in_ready(ir80), .in_pt(pt80),
    .in_key(key80), .out_valid(ov80), .out_ready(or80), .out_ct(ct80),
    .busy(busy80)
  );

  present_enc_ctrl #(.KEY_LEN(128)) dut128 (
    .clk(clk), .rst(rst), .in_valid(iv128), .in_ready(ir128), .in_pt(pt128),
    .in_key(key128), .out_valid(ov128), .out_ready(or128), .out_ct(ct128),
    .busy(busy128)
  );

  typedef struct {
    logic [63:0] ct;
    int          acc;
  } exp_t;

  exp_t q80[$];
  exp_t q128[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic ov80_prev = 1'b0;
  logic ov128_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref128(input logic [63:0] pt, input logic [127:0] key);
    logic [63:0]  s, t;
    logic [127:0] k;
    logic [3:0]   sb [16];
    sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[127:64];
      for (int j = 0; j < 16; j++) s[4*j +: 4] = sb[s[4*j +: 4]];
      t = '0;
      for (int b = 0; b < 64; b++) t[(b / 4) + 16 * (b % 4)] = s[b];
      s = t;
      k = (k << 61) | (k >> 67);
      k[127:124] = sb[k[127:124]];
      k[123:120] = sb[k[123:120]];
      k[66:62]   = k[66:62] ^ 5'(r);
    end
    return s ^ k[127:64];
  endfunction

  // Monitors: sample just after the falling edge, when stimulus has settled
  always @(negedge clk) begin
    #1;
    if (!rst && ov80) begin
      if (q80.size() == 0) begin
        chk("unexpected_out80", 64'd1, 64'd0);
      end else begin
        if (!ov80_prev) chk("latency80", 64'(cyc - q80[0].acc), 64'd31);
        chk("ct80", ct80, q80[0].ct);
        chk("in_ready_done80", 64'(ir80), 64'd0);
        if (or80) void'(q80.pop_front());
      end
    end
    ov80_prev = ov80 && !rst;
  end

  always @(negedge clk) begin
    #1;
    if (!rst && ov128) begin
      if (q128.size() == 0) begin
        chk("unexpected_out128", 64'd1, 64'd0);
      end else begin
        if (!ov128_prev) chk("latency128", 64'(cyc - q128[0].acc), 64'd31);
        if (or128) begin
          chk("ct128", ct128, q128[0].ct);
          void'(q128.pop_front());
        end
      end
    end
    ov128_prev = ov128 && !rst;
  end

  task automatic send80(input logic [63:0] pt, input logic [79:0] key,
                        input logic [63:0] exp, input bit keep, output int acc);
    int n = 0;
    pt80  = pt;
    key80 = key;
    iv80  = 1'b1;
    while (!ir80 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept80_timeout", 64'(n < 100), 64'd1);
    acc = cyc + 1;
    q80.push_back('{ct: exp, acc: acc});
    @(negedge clk);
    if (!keep) iv80 = 1'b0;
  endtask

  task automatic send128(input logic [63:0] pt, input logic [127:0] key, output int acc);
    int n = 0;
    pt128  = pt;
    key128 = key;
    iv128  = 1'b1;
    while (!ir128 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept128_timeout", 64'(n < 100), 64'd1);
    acc = cyc + 1;
    q128.push_back('{ct: ref128(pt, key), acc: acc});
    @(negedge clk);
    iv128 = 1'b0;
  endtask

  task automatic drain80();
    int n = 0;
    while (q80.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain80_timeout", 64'(n < 200), 64'd1);
  endtask

  task automatic drain128();
    int n = 0;
    while (q128.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain128_timeout", 64'(n < 200), 64'd1);
  endtask

  task automatic wait_ov80();
    int n = 0;
    while (!ov80 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid80_timeout", 64'(n < 60), 64'd1);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q80.delete();
    chk({tag, "_in_ready"},  64'(ir80),   64'd1);
    chk({tag, "_out_valid"}, 64'(ov80),   64'd0);
    chk({tag, "_out_ct"},    ct80,        64'd0);
    chk({tag, "_busy"},      64'(busy80), 64'd0);
  endtask

  localparam logic [63:0]  ONES64  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [79:0]  ONES80  = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0]  CT_ZZ   = 64'h5579_C138_7B22_8445;
  localparam logic [63:0]  CT_ZO   = 64'hE72C_46C0_F594_5049;
  localparam logic [63:0]  CT_OZ   = 64'hA112_FFC7_2F68_417B;
  localparam logic [63:0]  CT_OO   = 64'h3333_DCD3_2132_10D2;

  initial begin
    int a1, a2;
    rst = 1'b1;
    iv80 = 1'b0; or80 = 1'b1; pt80 = '0; key80 = '0;
    iv128 = 1'b0; or128 = 1'b1; pt128 = '0; key128 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready80",   64'(ir80),    64'd1);
    chk("rst_out_valid80",  64'(ov80),    64'd0);
    chk("rst_out_ct80",     ct80,         64'd0);
    chk("rst_busy80",       64'(busy80),  64'd0);
    chk("rst_in_ready128",  64'(ir128),   64'd1);
    chk("rst_out_valid128", 64'(ov128),   64'd0);

    // Directed 80-bit vectors
    send80('0, '0, CT_ZZ, 1'b0, a1);
    chk("busy_run80", 64'(busy80), 64'd1);
    drain80();
    send80('0, ONES80, CT_ZO, 1'b0, a1);
    drain80();
    send80(ONES64, '0, CT_OZ, 1'b0, a1);
    drain80();

    // Backpressure in DONE with ignored input pulses
    or80 = 1'b0;
    send80(ONES64, ONES80, CT_OO, 1'b0, a1);
    wait_ov80();
    for (int i = 0; i < 10; i++) begin
      iv80  = ~iv80;
      pt80  = {$urandom, $urandom};
      key80 = {16'($urandom), $urandom, $urandom};
      chk("busy_hold80", 64'(busy80), 64'd1);
      @(negedge clk);
    end
    iv80 = 1'b0;
    or80 = 1'b1;
    drain80();

    // Back-to-back with in_valid held high
    send80('0, '0, CT_ZZ, 1'b1, a1);
    send80(ONES64, '0, CT_OZ, 1'b0, a2);
    chk("issue_interval80", 64'(a2 - a1), 64'd33);
    drain80();

    // Reset mid-RUN, then reset while in DONE
    send80(ONES64, ONES80, CT_OO, 1'b0, a1);
    repeat (13) @(negedge clk);
    pulse_reset("rst_run");
    or80 = 1'b0;
    send80('0, '0, CT_ZZ, 1'b0, a1);
    wait_ov80();
    repeat (2) @(negedge clk);
    pulse_reset("rst_done");
    or80 = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_rst80", 64'(ov80), 64'd0);
    send80('0, '0, CT_ZZ, 1'b0, a1);
    drain80();

    // 128-bit key: random blocks against the reference model
    for (int i = 0; i < 50; i++) begin
      send128({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, a1);
      drain128();
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
